// File: rtl/wb_arb_pkg.sv
// Shared types and sizing helpers for the round-robin Wishbone arbiter.
package wb_arb_pkg;

    // Arbiter transaction phases.
    typedef enum logic [1:0] {
        IDLE = 2'd0,
        REQ  = 2'd1,
        WAIT = 2'd2
    } arb_state_e;

    // Slave response classes; the encoding grows with priority.
    typedef enum logic [1:0] {
        RESP_NONE = 2'd0,
        RESP_ACK  = 2'd1,
        RESP_RTY  = 2'd2,
        RESP_ERR  = 2'd3
    } resp_e;

    // Collapse simultaneous slave responses: err beats rty beats ack.
    function automatic resp_e resp_decode(input logic ack, input logic err, input logic rty);
        if (err)      return RESP_ERR;
        else if (rty) return RESP_RTY;
        else if (ack) return RESP_ACK;
        else          return RESP_NONE;
    endfunction

    // Timeout counter width; keeps one bit when the timeout is disabled.
    function automatic int cnt_width(input int timeout);
        return (timeout <= 0) ? 1 : $clog2(timeout + 1);
    endfunction

    // Width of a master index.
    function automatic int idx_width(input int n);
        return (n <= 1) ? 1 : $clog2(n);
    endfunction

endpackage

// File: rtl/wb_rr_arbiter_rr_picker.sv
// Combinational round-robin pick: first requester strictly after last_i.
module rr_picker
    import wb_arb_pkg::*;
#(
    parameter int N  = 2,
    parameter int IW = idx_width(N)
) (
    input  logic [N-1:0]  req_i,
    input  logic [IW-1:0] last_i,
    output logic          valid_o,
    output logic [IW-1:0] index_o
);

    logic [2*N-1:0] dbl;
    logic [N-1:0]   rot;
    int             pos;
    int             sum;

    // Rotate the request vector so bit 0 is the master right after last_i,
    // then take the lowest set bit and map it back to a master number.
    always_comb begin
        dbl     = {req_i, req_i};
        rot     = N'(dbl >> (int'(last_i) + 1));
        pos     = 0;
        for (int i = N - 1; i >= 0; i--) begin
            if (rot[i]) pos = i;
        end
        sum     = int'(last_i) + 1 + pos;
        if (sum >= N) sum = sum - N;
        valid_o = |req_i;
        index_o = IW'(sum);
    end

endmodule

// File: rtl/wb_rr_arbiter.sv
// Round-robin Wishbone B4 pipelined arbiter: N masters share one slave,
// one transaction outstanding, responses routed to the granted master only,
// with a bus-error timeout so a dead slave cannot lock the bus.
module wb_rr_arbiter
    import wb_arb_pkg::*;
#(
    parameter int N_MASTERS  = 2,
    parameter int ADDR_WIDTH = 8,
    parameter int TIMEOUT    = 255
) (
    input  logic                            clk_i,
    input  logic                            rst_n_i,
    input  logic [N_MASTERS-1:0]            m_cyc_i,
    input  logic [N_MASTERS-1:0]            m_stb_i,
    input  logic [N_MASTERS-1:0]            m_we_i,
    input  logic [N_MASTERS*ADDR_WIDTH-1:0] m_adr_i,
    input  logic [N_MASTERS*4-1:0]          m_sel_i,
    input  logic [N_MASTERS*32-1:0]         m_dat_i,
    output logic [N_MASTERS-1:0]            m_ack_o,
    output logic [N_MASTERS-1:0]            m_err_o,
    output logic [N_MASTERS-1:0]            m_rty_o,
    output logic [N_MASTERS-1:0]            m_stall_o,
    output logic [31:0]                     m_dat_o,
    output logic                            s_cyc_o,
    output logic                            s_stb_o,
    output logic                            s_we_o,
    output logic [ADDR_WIDTH-1:0]           s_adr_o,
    output logic [3:0]                      s_sel_o,
    output logic [31:0]                     s_dat_o,
    input  logic                            s_ack_i,
    input  logic                            s_err_i,
    input  logic                            s_rty_i,
    input  logic                            s_stall_i,
    input  logic [31:0]                     s_dat_i
);

    localparam int            IW     = idx_width(N_MASTERS);
    localparam int            CW     = cnt_width(TIMEOUT);
    localparam logic [CW-1:0] TO_VAL = CW'(TIMEOUT);
    localparam bit            TO_EN  = (TIMEOUT != 0);

    arb_state_e            state_q, state_d;
    // The grant register doubles as last_grant for the rotation.
    logic [IW-1:0]         gnt_q, gnt_d;
    logic [ADDR_WIDTH-1:0] adr_q, adr_d;
    logic [3:0]            sel_q, sel_d;
    logic                  we_q, we_d;
    logic [31:0]           dat_q, dat_d;
    logic [CW-1:0]         cnt_q, cnt_d;
    logic                  abort_q, abort_d;
    logic [N_MASTERS-1:0]  m_ack_q, m_ack_d;
    logic [N_MASTERS-1:0]  m_err_q, m_err_d;
    logic [N_MASTERS-1:0]  m_rty_q, m_rty_d;
    logic [31:0]           m_dat_q, m_dat_d;

    logic [N_MASTERS-1:0]  req;
    logic                  pick_valid;
    logic [IW-1:0]         pick_idx;
    resp_e                 resp;
    logic                  resp_taken;
    logic                  live;

    assign req = m_cyc_i & m_stb_i;

    rr_picker #(
        .N  (N_MASTERS),
        .IW (IW)
    ) u_picker (
        .req_i   (req),
        .last_i  (gnt_q),
        .valid_o (pick_valid),
        .index_o (pick_idx)
    );

    // Next-state, capture, timeout and response routing.
    always_comb begin
        state_d    = state_q;
        gnt_d      = gnt_q;
        adr_d      = adr_q;
        sel_d      = sel_q;
        we_d       = we_q;
        dat_d      = dat_q;
        cnt_d      = cnt_q;
        abort_d    = abort_q;
        m_ack_d    = '0;
        m_err_d    = '0;
        m_rty_d    = '0;
        m_dat_d    = m_dat_q;
        resp       = resp_decode(s_ack_i, s_err_i, s_rty_i);
        // A response counts in REQ only on the cycle the slave accepts.
        resp_taken = (resp != RESP_NONE) && ((state_q == WAIT) || !s_stall_i);
        // Deliver nothing once the granted master has dropped its cycle.
        live       = !abort_q && m_cyc_i[gnt_q];

        case (state_q)
            IDLE: begin
                if (pick_valid) begin
                    gnt_d   = pick_idx;
                    adr_d   = m_adr_i[pick_idx*ADDR_WIDTH +: ADDR_WIDTH];
                    sel_d   = m_sel_i[pick_idx*4 +: 4];
                    we_d    = m_we_i[pick_idx];
                    dat_d   = m_dat_i[pick_idx*32 +: 32];
                    cnt_d   = '0;
                    abort_d = 1'b0;
                    state_d = REQ;
                end
            end
            REQ, WAIT: begin
                cnt_d = cnt_q + 1'b1;
                if (!m_cyc_i[gnt_q]) abort_d = 1'b1;
                if (resp_taken) begin
                    if (live) begin
                        case (resp)
                            RESP_ERR: m_err_d[gnt_q] = 1'b1;
                            RESP_RTY: m_rty_d[gnt_q] = 1'b1;
                            RESP_ACK: begin
                                m_ack_d[gnt_q] = 1'b1;
                                m_dat_d        = s_dat_i;
                            end
                            default: ;
                        endcase
                    end
                    state_d = IDLE;
                end else if (TO_EN && (cnt_q == TO_VAL)) begin
                    if (live) m_err_d[gnt_q] = 1'b1;
                    state_d = IDLE;
                end else if ((state_q == REQ) && !s_stall_i) begin
                    state_d = WAIT;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    // State and capture registers; reset drops the slave cycle immediately.
    always_ff @(posedge clk_i or negedge rst_n_i) begin
        if (!rst_n_i) begin
            state_q <= IDLE;
            gnt_q   <= IW'(N_MASTERS - 1);
            adr_q   <= '0;
            sel_q   <= '0;
            we_q    <= 1'b0;
            dat_q   <= '0;
            cnt_q   <= '0;
            abort_q <= 1'b0;
            m_ack_q <= '0;
            m_err_q <= '0;
            m_rty_q <= '0;
            m_dat_q <= '0;
        end else begin
            state_q <= state_d;
            gnt_q   <= gnt_d;
            adr_q   <= adr_d;
            sel_q   <= sel_d;
            we_q    <= we_d;
            dat_q   <= dat_d;
            cnt_q   <= cnt_d;
            abort_q <= abort_d;
            m_ack_q <= m_ack_d;
            m_err_q <= m_err_d;
            m_rty_q <= m_rty_d;
            m_dat_q <= m_dat_d;
        end
    end

    // Only the IDLE-cycle winner sees stall low; everyone stalls otherwise.
    always_comb begin
        m_stall_o = '1;
        if (rst_n_i && (state_q == IDLE) && pick_valid) m_stall_o[pick_idx] = 1'b0;
    end

    assign s_cyc_o = (state_q != IDLE);
    assign s_stb_o = (state_q == REQ);
    assign s_we_o  = we_q;
    assign s_adr_o = adr_q;
    assign s_sel_o = sel_q;
    assign s_dat_o = dat_q;
    assign m_ack_o = m_ack_q;
    assign m_err_o = m_err_q;
    assign m_rty_o = m_rty_q;
    assign m_dat_o = m_dat_q;

endmodule

// File: tb/tb_wb_rr_arbiter.sv
// Directed bench for wb_rr_arbiter with two masters and TIMEOUT=4.
module tb_wb_rr_arbiter;

    logic        clk_i = 1'b0;
    logic        rst_n_i;
    logic [1:0]  m_cyc_i, m_stb_i, m_we_i;
    logic [15:0] m_adr_i;
    logic [7:0]  m_sel_i;
    logic [63:0] m_dat_i;
    logic [1:0]  m_ack_o, m_err_o, m_rty_o, m_stall_o;
    logic [31:0] m_dat_o;
    logic        s_cyc_o, s_stb_o, s_we_o;
    logic [7:0]  s_adr_o;
    logic [3:0]  s_sel_o;
    logic [31:0] s_dat_o;
    logic        s_ack_i, s_err_i, s_rty_i, s_stall_i;
    logic [31:0] s_dat_i;

    int vectors = 0;
    int miscompares = 0;

    wb_rr_arbiter #(
        .N_MASTERS  (2),
        .ADDR_WIDTH (8),
        .TIMEOUT    (4)
    ) dut (
        .clk_i     (clk_i),
        .rst_n_i   (rst_n_i),
        .m_cyc_i   (m_cyc_i),
        .m_stb_i   (m_stb_i),
        .m_we_i    (m_we_i),
        .m_adr_i   (m_adr_i),
        .m_sel_i   (m_sel_i),
        .m_dat_i   (m_dat_i),
        .m_ack_o   (m_ack_o),
        .m_err_o   (m_err_o),
        .m_rty_o   (m_rty_o),
        .m_stall_o (m_stall_o),
        .m_dat_o   (m_dat_o),
        .s_cyc_o   (s_cyc_o),
        .s_stb_o   (s_stb_o),
        .s_we_o    (s_we_o),
        .s_adr_o   (s_adr_o),
        .s_sel_o   (s_sel_o),
        .s_dat_o   (s_dat_o),
        .s_ack_i   (s_ack_i),
        .s_err_i   (s_err_i),
        .s_rty_i   (s_rty_i),
        .s_stall_i (s_stall_i),
        .s_dat_i   (s_dat_i)
    );

    always #5 clk_i = ~clk_i;

    task automatic tick();
        @(posedge clk_i);
        #1;
    endtask

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        vectors++;
        assert (obs === exp) else begin
            miscompares++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic set_m(input int i, input logic cyc, input logic stb, input logic we,
                         input logic [7:0] adr, input logic [31:0] dat);
        m_cyc_i[i]          = cyc;
        m_stb_i[i]          = stb;
        m_we_i[i]           = we;
        m_adr_i[i*8 +: 8]   = adr;
        m_sel_i[i*4 +: 4]   = 4'hF;
        m_dat_i[i*32 +: 32] = dat;
    endtask

    initial begin
        rst_n_i = 1'b0;
        m_cyc_i = '0; m_stb_i = '0; m_we_i = '0;
        m_adr_i = '0; m_sel_i = '0; m_dat_i = '0;
        s_ack_i = 1'b0; s_err_i = 1'b0; s_rty_i = 1'b0; s_stall_i = 1'b0;
        s_dat_i = '0;

        // Reset state
        tick(); tick();
        chk("rst_s_cyc", s_cyc_o, 0);
        chk("rst_s_stb", s_stb_o, 0);
        chk("rst_stall", m_stall_o, 2'b11);
        chk("rst_m_ack", m_ack_o, 0);
        chk("rst_m_err", m_err_o, 0);
        chk("rst_m_dat", m_dat_o, 0);
        chk("rst_s_adr", s_adr_o, 0);
        set_m(0, 1, 1, 1, 8'h10, 32'h1111_0000);
        set_m(1, 1, 1, 1, 8'h20, 32'h2222_0000);
        #1 chk("rst_stall_req", m_stall_o, 2'b11);

        // Fairness: both request continuously, grants alternate from master 0
        rst_n_i = 1'b1;
        #1;
        for (int t = 0; t < 8; t++) begin
            chk("fair_stall", m_stall_o, (t % 2) ? 2'b01 : 2'b10);
            tick();
            chk("fair_adr", s_adr_o, (t % 2) ? 8'h20 : 8'h10);
            chk("fair_stb", s_stb_o, 1);
            tick();
            s_ack_i = 1'b1;
            tick();
            s_ack_i = 1'b0;
            if (t == 7) begin
                set_m(0, 0, 0, 0, 8'h00, 32'h0);
                set_m(1, 0, 0, 0, 8'h00, 32'h0);
            end
            #1 chk("fair_ack", m_ack_o, (t % 2) ? 2'b10 : 2'b01);
        end
        tick();
        chk("fair_idle_cyc", s_cyc_o, 0);
        chk("fair_ack_clr", m_ack_o, 0);

        // Single master write, ack two cycles after strobe
        set_m(0, 1, 1, 1, 8'h04, 32'hDEAD_BEEF);
        #1 chk("wr_stall", m_stall_o, 2'b10);
        tick();
        m_stb_i[0] = 1'b0;
        chk("wr_s_cyc", s_cyc_o, 1);
        chk("wr_s_stb", s_stb_o, 1);
        chk("wr_s_adr", s_adr_o, 8'h04);
        chk("wr_s_dat", s_dat_o, 32'hDEAD_BEEF);
        chk("wr_s_we", s_we_o, 1);
        chk("wr_s_sel", s_sel_o, 4'hF);
        chk("wr_stall_busy", m_stall_o, 2'b11);
        tick();
        chk("wr_wait_stb", s_stb_o, 0);
        chk("wr_wait_cyc", s_cyc_o, 1);
        tick();
        s_ack_i = 1'b1;
        #1 chk("wr_ack_early", m_ack_o, 0);
        tick();
        s_ack_i = 1'b0;
        chk("wr_ack_c4", m_ack_o, 2'b01);
        m_cyc_i[0] = 1'b0;
        tick();
        chk("wr_ack_pulse", m_ack_o, 0);
        chk("wr_cyc_drop", s_cyc_o, 0);

        // Slave stalls three cycles; read returns 0x2 with the ack
        set_m(0, 1, 1, 0, 8'h08, 32'h0);
        s_stall_i = 1'b1;
        #1 chk("st_stall", m_stall_o, 2'b10);
        tick();
        m_stb_i[0] = 1'b0;
        chk("st_stb1", s_stb_o, 1);
        chk("st_adr1", s_adr_o, 8'h08);
        tick();
        chk("st_stb2", s_stb_o, 1);
        chk("st_adr2", s_adr_o, 8'h08);
        tick();
        chk("st_stb3", s_stb_o, 1);
        chk("st_adr3", s_adr_o, 8'h08);
        tick();
        s_stall_i = 1'b0;
        s_ack_i   = 1'b1;
        s_dat_i   = 32'h0000_0002;
        #1 chk("st_stb4", s_stb_o, 1);
        chk("st_we", s_we_o, 0);
        tick();
        s_ack_i = 1'b0;
        s_dat_i = '0;
        chk("st_ack", m_ack_o, 2'b01);
        chk("st_dat", m_dat_o, 32'h0000_0002);
        chk("st_cyc_drop", s_cyc_o, 0);
        m_cyc_i[0] = 1'b0;

        // Timeout on master 1, then master 0 is granted; err beats ack
        set_m(0, 1, 1, 1, 8'h10, 32'hAAAA_0000);
        set_m(1, 1, 1, 1, 8'h30, 32'hBBBB_0000);
        #1 chk("to_stall", m_stall_o, 2'b01);
        tick();
        m_stb_i[1] = 1'b0;
        chk("to_adr", s_adr_o, 8'h30);
        tick(); tick(); tick(); tick();
        chk("to_cyc_c5", s_cyc_o, 1);
        chk("to_err_c5", m_err_o, 0);
        tick();
        chk("to_err", m_err_o, 2'b10);
        chk("to_cyc_drop", s_cyc_o, 0);
        chk("to_next_stall", m_stall_o, 2'b10);
        m_cyc_i[1] = 1'b0;
        tick();
        chk("to_err_pulse", m_err_o, 0);
        chk("to_next_adr", s_adr_o, 8'h10);
        chk("to_next_stb", s_stb_o, 1);
        m_stb_i[0] = 1'b0;
        tick();
        s_err_i = 1'b1;
        s_ack_i = 1'b1;
        tick();
        s_err_i = 1'b0;
        s_ack_i = 1'b0;
        chk("sim_err", m_err_o, 2'b01);
        chk("sim_ack", m_ack_o, 2'b00);
        m_cyc_i[0] = 1'b0;

        // Response arriving in the timeout cycle wins
        set_m(1, 1, 1, 0, 8'h40, 32'h0);
        #1 chk("tc_stall", m_stall_o, 2'b01);
        tick();
        m_stb_i[1] = 1'b0;
        tick(); tick(); tick(); tick();
        s_ack_i = 1'b1;
        s_dat_i = 32'h0000_0055;
        tick();
        s_ack_i = 1'b0;
        chk("tc_ack", m_ack_o, 2'b10);
        chk("tc_err", m_err_o, 2'b00);
        chk("tc_dat", m_dat_o, 32'h0000_0055);
        tick();
        chk("tc_no_late_err", m_err_o, 2'b00);
        chk("tc_ack_pulse", m_ack_o, 2'b00);
        m_cyc_i[1] = 1'b0;

        // Master 1 aborts in WAIT: slave completes, response discarded
        set_m(1, 1, 1, 1, 8'h50, 32'h1234_5678);
        #1 chk("ab_stall", m_stall_o, 2'b01);
        tick();
        m_stb_i[1] = 1'b0;
        tick();
        m_cyc_i[1] = 1'b0;
        #1 chk("ab_cyc_hold", s_cyc_o, 1);
        tick();
        s_ack_i = 1'b1;
        s_dat_i = 32'h0000_0077;
        tick();
        s_ack_i = 1'b0;
        chk("ab_no_ack", m_ack_o, 2'b00);
        chk("ab_no_err", m_err_o, 2'b00);
        chk("ab_dat_keep", m_dat_o, 32'h0000_0055);
        chk("ab_cyc_drop", s_cyc_o, 0);
        set_m(0, 1, 1, 1, 8'h60, 32'h6666_0000);
        #1 chk("ab_next_stall", m_stall_o, 2'b10);
        tick();
        m_stb_i[0] = 1'b0;
        chk("ab_next_adr", s_adr_o, 8'h60);
        tick();
        s_ack_i = 1'b1;
        s_dat_i = 32'h0000_0099;
        tick();
        s_ack_i = 1'b0;
        chk("ab_next_ack", m_ack_o, 2'b01);
        chk("ab_next_dat", m_dat_o, 32'h0000_0099);
        m_cyc_i[0] = 1'b0;

        // Reset during REQ: cycle drops at once, master 0 wins afterwards
        set_m(1, 1, 1, 1, 8'h70, 32'h7777_0000);
        tick();
        chk("rr_cyc_req", s_cyc_o, 1);
        rst_n_i = 1'b0;
        #1 chk("rr_cyc_async", s_cyc_o, 0);
        chk("rr_stb_async", s_stb_o, 0);
        chk("rr_stall_async", m_stall_o, 2'b11);
        set_m(0, 1, 1, 1, 8'h80, 32'h8888_0000);
        tick(); tick();
        chk("rr_ack_none", m_ack_o, 2'b00);
        rst_n_i = 1'b1;
        #1 chk("rr_first_stall", m_stall_o, 2'b10);
        tick();
        chk("rr_first_adr", s_adr_o, 8'h80);
        set_m(0, 0, 0, 0, 8'h00, 32'h0);
        set_m(1, 0, 0, 0, 8'h00, 32'h0);
        tick();

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule

// File: doc/wb_rr_arbiter.md
# wb_rr_arbiter

Round-robin Wishbone B4 pipelined arbiter that lets N_MASTERS bus masters share one Wishbone slave port. That slave port is typically a generated register bank, such as a strobe-register block with a 32-bit data bus and a wr-in/rd-out pipeline. The arbiter keeps one transaction outstanding at a time, forwards ack/err/rty only to the granted master, and generates a bus error on timeout so a dead slave cannot lock the bus.

## Interface
- N_MASTERS, 2: number of requesting masters (2..8).
- ADDR_WIDTH, 8: byte address width forwarded to the slave.
- TIMEOUT, 255: cycles allowed from slave strobe to response; 0 disables the timeout.
- clk_i  in  1  single clock, all logic on rising edge.
- rst_n_i  in  1  reset, asynchronous assert, active-low.
- m_cyc_i, m_stb_i, m_we_i  in  N_MASTERS each  per-master cycle, strobe and write-enable.
- m_adr_i  in  N_MASTERS*ADDR_WIDTH  addresses; master i occupies slice i.
- m_sel_i  in  N_MASTERS*4  byte selects.
- m_dat_i  in  N_MASTERS*32  write data.
- m_ack_o, m_err_o, m_rty_o  out  N_MASTERS each  registered per-master responses.
- m_stall_o  out  N_MASTERS  per-master stall.
- m_dat_o  out  32  read data shared by all masters; valid with m_ack_o.
- s_cyc_o, s_stb_o, s_we_o  out  1  slave cycle, strobe and write-enable.
- s_adr_o  out  ADDR_WIDTH  slave address.
- s_sel_o  out  4  slave byte selects.
- s_dat_o  out  32  slave write data.
- s_ack_i, s_err_i, s_rty_i, s_stall_i  in  1  slave responses and stall.
- s_dat_i  in  32  slave read data.

## Operation
- Master i requests when m_cyc_i[i] & m_stb_i[i].
- **FSM state IDLE:**
  - Pick the first requester strictly after last_grant, in circular order.
  - The winner sees m_stall_o low in that same cycle. Capture its adr/sel/we/dat and index into registers, update last_grant, go to REQ.
  - All other requesters see stall high.
- **FSM state REQ:**
  - s_cyc_o=1 and s_stb_o=1, driven from the captured registers.
  - When s_stall_i=0, go to WAIT.
  - If s_ack_i/s_err_i/s_rty_i arrives in that same accept cycle, complete directly (see WAIT).
- **FSM state WAIT:**
  - s_cyc_o=1, s_stb_o=0.
  - On the first cycle with ack/err/rty: register the matching m_*_o[grant]=1 for exactly one cycle and m_dat_o<=s_dat_i (ack only). Go to IDLE.
  - Priority when several responses arrive together: err > rty > ack.
- **m_stall_o:** all ones outside IDLE and while rst_n_i=0.
- **Timeout counter:**
  - Width $clog2(TIMEOUT+1); cleared on grant; increments in REQ and WAIT.
  - When it equals TIMEOUT with no response: pulse m_err_o[grant], drop s_cyc_o the next cycle, go to IDLE.
  - A slave response arriving in the timeout cycle wins over the timeout.
- **Master abort:** if the granted master drops m_cyc_i mid-transaction, the slave transaction still completes. Its response is discarded (no m_*_o pulse).
- **Reset values:**
  - state=IDLE, last_grant=N_MASTERS-1 (master 0 wins first), counter=0.
  - All s_*_o=0, m_ack/err/rty_o=0, m_dat_o=0.
  - Reset mid-transaction: s_cyc_o falls asynchronously and no response is delivered.

## Timing
- Master request accepted in cycle 0; s_stb_o high from cycle 1.
- m_ack_o is high one cycle after s_ack_i.
- Against a slave that acks 2 cycles after an unstalled strobe, master sees ack at cycle 4.
- A new grant can occur in the same cycle m_ack_o of the previous transaction is high. Back-to-back throughput is one transaction per slave round trip +2.
- s_cyc_o is continuous from REQ entry through the response cycle, and low for at least one cycle between grants.

## Structure
- Package wb_arb_pkg holds:
  - state enum (IDLE, REQ, WAIT);
  - the response-priority encoding;
  - the function computing the counter width.
- Sub-module rr_picker: combinational round-robin priority rotate.
  - Inputs: req vector, last_grant.
  - Outputs: valid, index.
- The top level holds the FSM, capture registers and timeout counter.

## Test plan
- **Single master:** master 0 writes 0xDEADBEEF to adr 0x04, slave acks 2 cycles after strobe → s_dat_o=0xDEADBEEF, m_ack_o[0] pulse at cycle 4, m_ack_o[1] stays 0.
- **Fairness:** both masters request continuously from reset → grants alternate 0,1,0,1 over 8 transactions; each non-winner sees stall=1.
- **Slave stall:** s_stall_i=1 for 3 cycles → s_stb_o stays high 4 cycles, captured address stable throughout. Read of 0x00000002 returns m_dat_o=0x00000002 with the ack.
- **Timeout:** TIMEOUT=4, slave never responds → m_err_o[grant] pulses exactly one cycle; s_cyc_o low next cycle; the other master is granted afterwards.
- **Simultaneous events:**
  - s_err_i and s_ack_i in the same cycle → only m_err_o is pulsed.
  - Response in the timeout cycle → slave response delivered, no timeout error.
- **Abort and reset:**
  - Master 1 drops cyc in WAIT → no m_*_o[1] pulse; next grant proceeds normally.
  - rst_n_i low mid-REQ → s_cyc_o=0 immediately; after release master 0 wins first.
